// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DataWidth = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrantA = 2'd1,
    StGrantB = 2'd2
  } arb_state_e;

  localparam logic SelA = 1'b1;
  localparam logic SelB = 1'b0;

endpackage

// File: rtl/arb_timeout_counter.sv
// Grant-duration counter with clear/load/enable and an expiry flag at Limit-1.
module arb_timeout_counter #(
  parameter int unsigned Limit = 16,
  parameter int unsigned CntW  = $clog2(Limit + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            en_i,
  output logic            expired_o
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/mux2_32.sv
// 32-bit 2:1 multiplexer; sel_i=1 routes d1_i.
module mux2_32 (
  input  logic        sel_i,
  input  logic [31:0] d0_i,
  input  logic [31:0] d1_i,
  output logic [31:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between data access (A, r/w) and fetch (B, read-only),
// with a bounded A streak to prevent fetch starvation and a per-grant timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MaxAStreak = 4,
  parameter int unsigned Timeout    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req_i,
  input  logic                 a_we_i,
  input  logic [DataWidth-1:0] a_addr_i,
  input  logic [DataWidth-1:0] a_wdata_i,
  output logic [DataWidth-1:0] a_rdata_o,
  output logic                 a_ack_o,
  output logic                 a_err_o,
  input  logic                 b_req_i,
  input  logic [DataWidth-1:0] b_addr_i,
  output logic [DataWidth-1:0] b_rdata_o,
  output logic                 b_ack_o,
  output logic                 b_err_o,
  output logic                 sel_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [DataWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  input  logic                 mem_ack_i,
  output logic                 busy_o
);

  localparam int unsigned StreakW = $clog2(MaxAStreak + 1);
  localparam int unsigned TimerW  = $clog2(Timeout + 1);

  arb_state_e           state_q;
  logic                 sel_q;
  logic                 a_ack_q, b_ack_q, a_err_q, b_err_q;
  logic [DataWidth-1:0] a_rdata_q, b_rdata_q;
  logic [StreakW-1:0]   streak_q;

  logic granted;
  logic expired;
  logic streak_full;
  logic b_starved;

  assign granted     = (state_q != StIdle);
  assign streak_full = (streak_q == StreakW'(MaxAStreak));
  assign b_starved   = b_req_i && streak_full;

  arb_timeout_counter #(
    .Limit(Timeout),
    .CntW (TimerW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (!granted || mem_ack_i || expired),
    .load_i    (1'b0),
    .load_val_i({TimerW{1'b0}}),
    .en_i      (granted),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sel_q     <= SelB;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      streak_q  <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      a_err_q <= 1'b0;
      b_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (a_req_i && !b_starved) begin
            state_q <= StGrantA;
            sel_q   <= SelA;
            // Only consecutive A wins over a waiting fetch count towards the limit.
            if (!b_req_i) begin
              streak_q <= '0;
            end else if (!streak_full) begin
              streak_q <= streak_q + 1'b1;
            end
          end else if (b_req_i) begin
            state_q  <= StGrantB;
            sel_q    <= SelB;
            streak_q <= '0;
          end
        end
        StGrantA: begin
          if (mem_ack_i) begin
            a_rdata_q <= mem_rdata_i;
            a_ack_q   <= 1'b1;
            state_q   <= StIdle;
          end else if (expired) begin
            a_err_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        StGrantB: begin
          if (mem_ack_i) begin
            b_rdata_q <= mem_rdata_i;
            b_ack_q   <= 1'b1;
            state_q   <= StIdle;
          end else if (expired) begin
            b_err_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  mux2_32 u_addr_mux (
    .sel_i(sel_q),
    .d0_i (b_addr_i),
    .d1_i (a_addr_i),
    .y_o  (mem_addr_o)
  );

  // Fetch never writes, so the B leg of the write-data mux is tied low.
  mux2_32 u_wdata_mux (
    .sel_i(sel_q),
    .d0_i ({DataWidth{1'b0}}),
    .d1_i (a_wdata_i),
    .y_o  (mem_wdata_o)
  );

  assign mem_req_o = granted;
  assign busy_o    = granted;
  assign mem_we_o  = (state_q == StGrantA) && a_we_i;
  assign sel_o     = sel_q;
  assign a_ack_o   = a_ack_q;
  assign b_ack_o   = b_ack_q;
  assign a_err_o   = a_err_q;
  assign b_err_o   = b_err_q;
  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, a_ack, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_ack, b_err;
  logic [31:0] b_addr, b_rdata;
  logic        sel, mem_req, mem_we, mem_ack, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        auto_ack;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .MaxAStreak(4),
    .Timeout   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_req_i    (a_req),
    .a_we_i     (a_we),
    .a_addr_i   (a_addr),
    .a_wdata_i  (a_wdata),
    .a_rdata_o  (a_rdata),
    .a_ack_o    (a_ack),
    .a_err_o    (a_err),
    .b_req_i    (b_req),
    .b_addr_i   (b_addr),
    .b_rdata_o  (b_rdata),
    .b_ack_o    (b_ack),
    .b_err_o    (b_err),
    .sel_o      (sel),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .mem_ack_i  (mem_ack),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle responder used by the streak sequence.
  always @(negedge clk) if (auto_ack) mem_ack = mem_req;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one A transaction; mem_ack is returned in grant cycle ack_at (0 = never).
  task automatic run_a(input int ack_at, input logic [31:0] rdata,
                       output int nreq, output int nack, output int nerr);
    nreq = 0;
    nack = 0;
    nerr = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_req) nreq++;
      if (a_ack) nack++;
      if (a_err) nerr++;
      mem_ack   = mem_req && (nreq == ack_at);
      mem_rdata = rdata;
      if (a_ack || a_err) begin
        a_req = 1'b0;
        break;
      end
    end
  endtask

  logic exp_sel [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int   nreq, nack, nerr;

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_addr = 0;
    mem_ack = 0; mem_rdata = 0; auto_ack = 0;

    // Reset state
    step();
    step();
    check("rst_sel", sel, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_acks", {a_ack, b_ack, a_err, b_err}, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    rst_n = 1'b1;
    step();

    // A read, ack in second grant cycle
    a_req = 1; a_we = 0; a_addr = 32'h10;
    step();
    check("ard_req", mem_req, 1);
    check("ard_sel", sel, 1);
    check("ard_addr", mem_addr, 32'h10);
    check("ard_we", mem_we, 0);
    check("ard_busy", busy, 1);
    step();
    check("ard_req2", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 0;
    check("ard_ack", a_ack, 1);
    check("ard_rdata", a_rdata, 32'hDEADBEEF);
    check("ard_idle", mem_req, 0);
    a_req = 0;
    step();
    check("ard_ack_pulse", a_ack, 0);

    // A write that never acks
    a_req = 1; a_we = 1; a_addr = 32'h20; a_wdata = 32'h12345678;
    step();
    check("awr_we", mem_we, 1);
    check("awr_addr", mem_addr, 32'h20);
    check("awr_wdata", mem_wdata, 32'h12345678);
    run_a(0, 32'h0, nreq, nack, nerr);
    check("to_req_cycles", nreq + 1, 16);
    check("to_err", nerr, 1);
    check("to_no_ack", nack, 0);
    check("to_rdata_kept", a_rdata, 32'hDEADBEEF);
    check("to_idle", busy, 0);
    step();
    check("to_err_pulse", a_err, 0);

    // mem_ack coincides with timer expiry
    a_req = 1; a_we = 0; a_addr = 32'h30;
    run_a(16, 32'h55AA55AA, nreq, nack, nerr);
    check("tie_req_cycles", nreq, 16);
    check("tie_ack", nack, 1);
    check("tie_no_err", nerr, 0);
    check("tie_rdata", a_rdata, 32'h55AA55AA);
    step();

    // B alone
    b_req = 1; b_addr = 32'h400; a_we = 1; a_wdata = 32'hFFFFFFFF;
    step();
    check("b_sel", sel, 0);
    check("b_we", mem_we, 0);
    check("b_wdata", mem_wdata, 0);
    check("b_addr", mem_addr, 32'h400);
    check("b_req", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 0;
    check("b_ack", b_ack, 1);
    check("b_rdata", b_rdata, 32'hCAFEF00D);
    check("b_no_a_ack", a_ack, 0);
    b_req = 0; a_we = 0;
    step();

    // A and B held together: streak limit gives B every fifth grant
    a_req = 1; b_req = 1; auto_ack = 1;
    for (int g = 0; g < 10; g++) begin
      step();
      check($sformatf("strk_req%0d", g), mem_req, 1);
      check($sformatf("strk_sel%0d", g), sel, exp_sel[g]);
      step();
      check($sformatf("strk_gap%0d", g), mem_req, 0);
      check($sformatf("strk_ack%0d", g), {a_ack, b_ack}, {exp_sel[g], ~exp_sel[g]});
    end
    a_req = 0; b_req = 0; auto_ack = 0;
    #1 mem_ack = 0;
    step();
    check("strk_end_idle", mem_req, 0);

    // Reset in the middle of a B grant
    b_req = 1; b_addr = 32'h800;
    step();
    check("rstb_grant", busy, 1);
    step();
    a_req = 1; a_we = 0; a_addr = 32'h44;
    #2 rst_n = 1'b0;
    #1;
    check("rstb_req", mem_req, 0);
    check("rstb_busy", busy, 0);
    check("rstb_sel", sel, 0);
    b_req = 0;
    step();
    check("rstb_no_ack", {b_ack, b_err}, 0);
    rst_n = 1'b1;
    step();
    check("rstb_a_sel", sel, 1);
    check("rstb_a_req", mem_req, 1);
    check("rstb_a_addr", mem_addr, 32'h44);
    mem_ack = 1; mem_rdata = 32'h0F0F0F0F;
    step();
    mem_ack = 0;
    check("rstb_a_ack", a_ack, 1);
    check("rstb_b_quiet", b_ack, 0);
    a_req = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
